inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Dual-entry-per-cycle instruction queue between the dual-issue instruction cache and decode/issue.
- Accepts up to two instructions per cycle, each tagged with its PC, from the cache's data_ok1/data_ok2 outputs.
- Presents the two oldest entries to the dual-issue decoder and retires 0, 1 or 2 per cycle.
- Raises full so the fetch stage stalls, and discards all contents on pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (branch mispredict/exception)
- push_en1  in  1  slot-1 instruction valid (cache inst_data_ok1)
- push_en2  in  1  slot-2 instruction valid (cache inst_data_ok2)
- push_inst1  in  32  slot-1 instruction word
- push_inst2  in  32  slot-2 instruction word
- push_pc1  in  32  PC of slot-1 instruction
- push_pc2  in  32  PC of slot-2 instruction; must equal push_pc1+4
- pop_en1  in  1  decoder consumes head entry
- pop_en2  in  1  decoder consumes head+1 entry
- out_valid1  out  1  head entry valid
- out_valid2  out  1  head+1 entry valid
- out_inst1  out  32  head instruction
- out_inst2  out  32  head+1 instruction
- out_pc1  out  32  head PC
- out_pc2  out  32  head+1 PC
- full  out  1  fewer than 2 free entries; fetch must stall
- empty  out  1  count==0
- count  out  PTR_W+1  occupied entries

Behaviour:
- Storage: register arrays inst_q[DEPTH] and pc_q[DEPTH]. Pointers rd_ptr/wr_ptr are PTR_W bits and wrap modulo DEPTH naturally. count is a separate register, PTR_W+1 bits.
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0. Outputs after reset: out_valid1/2=0, empty=1, full=0, count=0. Array contents are don't-care; out_inst/out_pc show whatever the array holds.
- Outputs are combinational from registered state:
  - out_valid1 = count>=1; out_valid2 = count>=2.
  - out_inst1/out_pc1 = array[rd_ptr]; out_inst2/out_pc2 = array[rd_ptr+1] (wrapped).
  - full = count >= DEPTH-1; empty = count==0.
- Push acceptance:
  - push1 = push_en1 & ~full & ~flush.
  - push2 = push_en2 & push1.
  - push_en2 without push_en1 is illegal; it is ignored.
  - Fetch holds data while full; the queue never drops an accepted-valid entry silently.
- Push write: push1 writes slot 1 at wr_ptr; push2 writes slot 2 at wr_ptr+1. wr_ptr advances by push1+push2.
- Pop acceptance:
  - pop1 = pop_en1 & out_valid1 & ~flush.
  - pop2 = pop_en2 & pop1 & out_valid2.
  - pop_en2 without pop_en1 is ignored. rd_ptr advances by pop1+pop2.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no write-through bypass: an empty queue plus a push shows out_valid1=1 one cycle later.
- Simultaneous push and pop in the same cycle: count_next = count + push1 + push2 - pop1 - pop2. Writes never collide with reads, because full reserves 2 free slots.
- Full boundary: at count=DEPTH-2, full=0 and a double push is legal, reaching count=DEPTH. At count=DEPTH-1 or DEPTH, full=1 and no push is accepted, even if a pop occurs the same cycle. This conservative rule avoids a combinational pop-to-push path.
- Flush: has priority over push and pop. At the next edge rd_ptr=wr_ptr=0 and count=0. Same-cycle push and pop are discarded.
- rst has priority over flush.
- Wrap-around: pointer overflow from DEPTH-1 to 0 is seamless. A double push at wr_ptr=DEPTH-1 writes entries DEPTH-1 and 0.

Decomposition:
- Shared package (cpu_defs_pkg) holds:
  - typedef fq_entry_t {logic [31:0] inst; logic [31:0] pc;}
  - localparam FQ_DEPTH=16
- The queue is a single module with no sub-module. A separate flop-array memory adds nothing; the two write ports and two read ports are simple indexed accesses.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, out_valid1=out_valid2=0.
- Push (0x1111_0000 @ pc 0x1000, 0x2222_0000 @ pc 0x1004), no pop -> next cycle count=2, out_inst1=0x1111_0000, out_pc2=0x1004, out_valid2=1.
- Fill with 7 double pushes (count=14), then push 2 more -> count=16, full=1. A further push with pop_en1=1 the same cycle -> push ignored, count=15.
- Simultaneous push2 + pop2 at count=4 across the wrap (rd_ptr=14, wr_ptr=2) -> count stays 4; out_pc1 advances by 8; data order preserved.
- flush=1 with push_en1/2=1 and pop_en1/2=1 at count=5 -> next cycle count=0, empty=1, out_valid1=0.
- push_en2=1 with push_en1=0; pop_en2=1 with pop_en1=0 -> both ignored, count unchanged. pop_en1=1 on an empty queue -> count stays 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs_pkg
// Purpose  : Shared CPU definitions used by the fetch queue and its clients.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    // Default queue depth for the instruction fetch queue
    localparam int FQ_DEPTH = 16;

    // One queued instruction together with the PC it was fetched from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_if
// Purpose  : Push (cache side), pop (decoder side) and status bundle of the
//            instruction fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             push_en1;
    logic             push_en2;
    logic [31:0]      push_inst1;
    logic [31:0]      push_inst2;
    logic [31:0]      push_pc1;
    logic [31:0]      push_pc2;
    logic             pop_en1;
    logic             pop_en2;
    logic             out_valid1;
    logic             out_valid2;
    logic [31:0]      out_inst1;
    logic [31:0]      out_inst2;
    logic [31:0]      out_pc1;
    logic [31:0]      out_pc2;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

    // Pipeline side: drives pushes, pops and flush, observes the queue
    modport master (
        output flush, push_en1, push_en2, push_inst1, push_inst2,
               push_pc1, push_pc2, pop_en1, pop_en2,
        input  out_valid1, out_valid2, out_inst1, out_inst2,
               out_pc1, out_pc2, full, empty, count
    );

    // Queue side
    modport slave (
        input  flush, push_en1, push_en2, push_inst1, push_inst2,
               push_pc1, push_pc2, pop_en1, pop_en2,
        output out_valid1, out_valid2, out_inst1, out_inst2,
               out_pc1, out_pc2, full, empty, count
    );

endinterface : inst_fetch_queue_if
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Dual-push / dual-pop instruction queue between the dual-issue
//            instruction cache and the decoder. Keeps 2 slots in reserve so
//            a double push is always safe when full is low.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    inst_fetch_queue_if.slave  q
);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_w;
    logic             push1, push2, pop1, pop2;
    logic [PTR_W-1:0] rd_ptr_nxt1;
    logic [PTR_W-1:0] wr_ptr_nxt1;

    // Status and head-entry outputs, all from registered state only
    always_comb begin
        rd_ptr_nxt1  = rd_ptr_q + PTR_W'(1);
        full_w       = (count_q >= CNT_W'(DEPTH - 1));
        q.full       = full_w;
        q.empty      = (count_q == '0);
        q.count      = count_q;
        q.out_valid1 = (count_q >= CNT_W'(1));
        q.out_valid2 = (count_q >= CNT_W'(2));
        q.out_inst1  = mem_q[rd_ptr_q].inst;
        q.out_pc1    = mem_q[rd_ptr_q].pc;
        q.out_inst2  = mem_q[rd_ptr_nxt1].inst;
        q.out_pc2    = mem_q[rd_ptr_nxt1].pc;
    end

    // Handshake qualification: full is judged before any same-cycle pop so
    // there is no combinational path from pop_en to push acceptance
    always_comb begin
        push1 = q.push_en1 & ~full_w & ~q.flush;
        push2 = q.push_en2 & push1;
        pop1  = q.pop_en1 & q.out_valid1 & ~q.flush;
        pop2  = q.pop_en2 & pop1 & q.out_valid2;
    end

    // Next pointer / occupancy; flush discards everything
    always_comb begin
        wr_ptr_nxt1 = wr_ptr_q + PTR_W'(1);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop1) + PTR_W'(pop2);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push1) + PTR_W'(push2);
        count_d     = count_q + CNT_W'(push1) + CNT_W'(push2)
                              - CNT_W'(pop1)  - CNT_W'(pop2);
        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: slot 1 at wr_ptr, slot 2 at wr_ptr+1 (wraps naturally)
    always_ff @(posedge clk) begin
        if (push1) begin
            mem_q[wr_ptr_q] <= '{inst: q.push_inst1, pc: q.push_pc1};
        end
        if (push2) begin
            mem_q[wr_ptr_nxt1] <= '{inst: q.push_inst2, pc: q.push_pc2};
        end
    end

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Self-checking bench for inst_fetch_queue: a queue-based model
//            compared every cycle, plus hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;
    import cpu_defs_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: a plain queue of entries
    fq_entry_t mq[$];
    bit        model_live = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge from the inputs held during the cycle
    always @(posedge clk) begin
        int sz;
        bit p1, p2, o1, o2;
        sz = mq.size();
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            p1 = bus.push_en1 && (sz <= DEPTH - 2);
            p2 = bus.push_en2 && p1;
            o1 = bus.pop_en1 && (sz >= 1);
            o2 = bus.pop_en2 && o1 && (sz >= 2);
            if (o1) void'(mq.pop_front());
            if (o2) void'(mq.pop_front());
            if (p1) mq.push_back('{inst: bus.push_inst1, pc: bus.push_pc1});
            if (p2) mq.push_back('{inst: bus.push_inst2, pc: bus.push_pc2});
        end
        if (rst) model_live <= 1'b1;
    end

    // Every-cycle comparison on the inactive edge
    always @(negedge clk) begin
        if (model_live) begin
            int sz;
            sz = mq.size();
            chk("count",  64'(bus.count),      64'(sz));
            chk("empty",  64'(bus.empty),      64'(sz == 0));
            chk("full",   64'(bus.full),       64'(sz >= DEPTH - 1));
            chk("valid1", 64'(bus.out_valid1), 64'(sz >= 1));
            chk("valid2", 64'(bus.out_valid2), 64'(sz >= 2));
            if (sz >= 1) begin
                chk("inst1", 64'(bus.out_inst1), 64'(mq[0].inst));
                chk("pc1",   64'(bus.out_pc1),   64'(mq[0].pc));
            end
            if (sz >= 2) begin
                chk("inst2", 64'(bus.out_inst2), 64'(mq[1].inst));
                chk("pc2",   64'(bus.out_pc2),   64'(mq[1].pc));
            end
        end
    end

    task automatic idle();
        bus.flush    = 1'b0;
        bus.push_en1 = 1'b0;
        bus.push_en2 = 1'b0;
        bus.pop_en1  = 1'b0;
        bus.pop_en2  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read the settled outputs at the next inactive edge
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_push(input bit e1, input bit e2, input logic [31:0] pc,
                            input logic [31:0] i1, input logic [31:0] i2);
        bus.push_en1   = e1;
        bus.push_en2   = e2;
        bus.push_pc1   = pc;
        bus.push_pc2   = pc + 32'd4;
        bus.push_inst1 = i1;
        bus.push_inst2 = i2;
    endtask

    initial begin
        idle();
        set_push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_empty",  64'(bus.empty),      64'd1);
        chk("rst_full",   64'(bus.full),       64'd0);
        chk("rst_count",  64'(bus.count),      64'd0);
        chk("rst_valid1", 64'(bus.out_valid1), 64'd0);
        chk("rst_valid2", 64'(bus.out_valid2), 64'd0);

        // First double push, visible the cycle after
        tick();
        set_push(1'b1, 1'b1, 32'h1000, 32'h1111_0000, 32'h2222_0000);
        tick();
        idle();
        settle();
        chk("p1_count",  64'(bus.count),     64'd2);
        chk("p1_inst1",  64'(bus.out_inst1), 64'h1111_0000);
        chk("p1_pc2",    64'(bus.out_pc2),   64'h1004);
        chk("p1_valid2", 64'(bus.out_valid2), 64'd1);

        // Grow to 5, then flush with everything asserted
        tick();
        set_push(1'b1, 1'b0, 32'h1008, 32'h3333_0000, 32'h0);
        tick();
        set_push(1'b1, 1'b1, 32'h100C, 32'h4444_0000, 32'h5555_0000);
        tick();
        idle();
        settle();
        chk("pre_flush_count", 64'(bus.count), 64'd5);
        tick();
        set_push(1'b1, 1'b1, 32'h1014, 32'hdead_0000, 32'hdead_0004);
        bus.pop_en1 = 1'b1;
        bus.pop_en2 = 1'b1;
        bus.flush   = 1'b1;
        tick();
        idle();
        settle();
        chk("flush_count",  64'(bus.count),      64'd0);
        chk("flush_empty",  64'(bus.empty),      64'd1);
        chk("flush_valid1", 64'(bus.out_valid1), 64'd0);

        // Fill: 7 double pushes -> 14, then one more -> 16
        tick();
        for (int i = 0; i < 7; i++) begin
            set_push(1'b1, 1'b1, 32'h2000 + 32'(8 * i),
                     32'hA000_0000 + 32'(2 * i), 32'hA000_0001 + 32'(2 * i));
            tick();
        end
        idle();
        settle();
        chk("fill14_count", 64'(bus.count), 64'd14);
        chk("fill14_full",  64'(bus.full),  64'd0);
        tick();
        set_push(1'b1, 1'b1, 32'h2038, 32'hA000_000E, 32'hA000_000F);
        tick();
        idle();
        settle();
        chk("fill16_count", 64'(bus.count), 64'd16);
        chk("fill16_full",  64'(bus.full),  64'd1);

        // Push while full with a same-cycle pop: push must be refused
        tick();
        set_push(1'b1, 1'b1, 32'h3000, 32'hBAD0_0000, 32'hBAD0_0004);
        bus.pop_en1 = 1'b1;
        tick();
        idle();
        settle();
        chk("fullpop_count", 64'(bus.count),   64'd15);
        chk("fullpop_pc1",   64'(bus.out_pc1), 64'h2004);

        // Drain to rd_ptr=14, count=2, then refill 2 so wr_ptr=2, count=4
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.pop_en1 = 1'b1;
            bus.pop_en2 = 1'b1;
            tick();
        end
        bus.pop_en2 = 1'b0;
        tick();
        set_push(1'b1, 1'b1, 32'h2040, 32'hC000_0000, 32'hC000_0001);
        bus.pop_en1 = 1'b0;
        tick();
        idle();
        settle();
        chk("wrap_pre_count", 64'(bus.count),   64'd4);
        chk("wrap_pre_pc1",   64'(bus.out_pc1), 64'h2038);

        // Double push + double pop across the wrap point
        tick();
        set_push(1'b1, 1'b1, 32'h2048, 32'hC000_0002, 32'hC000_0003);
        bus.pop_en1 = 1'b1;
        bus.pop_en2 = 1'b1;
        tick();
        idle();
        settle();
        chk("wrap_count", 64'(bus.count),     64'd4);
        chk("wrap_pc1",   64'(bus.out_pc1),   64'h2040);
        chk("wrap_inst2", 64'(bus.out_inst2), 64'hC000_0001);

        // Illegal slot-2-only push and pop are ignored
        tick();
        set_push(1'b0, 1'b1, 32'h4000, 32'hEEEE_0000, 32'hEEEE_0004);
        bus.pop_en2 = 1'b1;
        tick();
        idle();
        settle();
        chk("illegal_count", 64'(bus.count),   64'd4);
        chk("illegal_pc1",   64'(bus.out_pc1), 64'h2040);

        // Drain completely, then pop on an empty queue
        tick();
        bus.pop_en1 = 1'b1;
        bus.pop_en2 = 1'b1;
        tick();
        tick();
        tick();
        idle();
        settle();
        chk("emptypop_count", 64'(bus.count), 64'd0);
        chk("emptypop_empty", 64'(bus.empty), 64'd1);

        // Mixed traffic patterns checked only by the model
        tick();
        for (int i = 0; i < 60; i++) begin
            set_push(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     32'h5000 + 32'(8 * i), $urandom, $urandom);
            bus.pop_en1 = 1'($urandom_range(0, 2) == 0);
            bus.pop_en2 = 1'($urandom_range(0, 1));
            bus.flush   = 1'($urandom_range(0, 29) == 0);
            tick();
        end
        idle();
        tick();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire
